// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter for the unified instruction/data memory port.
// Each access occupies MEM_LAT cycles on the memory bus, then pulses ack for one cycle.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [1:0]    gnt,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd
);

  localparam int CW = $clog2(MEM_LAT) + 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] wd;
  } acc_t;

  state_t        state, state_nx;
  logic [CW-1:0] count;
  logic          last;
  logic          sel;
  logic          win;
  logic          any_req;
  logic          last_cyc;
  acc_t          acc;

  assign any_req  = req0 | req1;
  // On a tie the port that did not go last wins; a lone request always wins.
  assign win      = (req0 & req1) ? ~last : req1;
  assign last_cyc = (count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = ACCESS;
      ACCESS:  if (last_cyc) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    gnt    = 2'b00;
    ack0   = 1'b0;
    ack1   = 1'b0;
    mem_we = 1'b0;
    case (state)
      ACCESS: begin
        gnt    = sel ? 2'b10 : 2'b01;
        mem_we = acc.we & last_cyc;
      end
      DONE: begin
        gnt  = sel ? 2'b10 : 2'b01;
        ack0 = ~sel;
        ack1 = sel;
      end
      default: ;
    endcase
  end

  // Access registers hold their contents through IDLE so the bus stays quiet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last   <= 1'b1;
      sel    <= 1'b0;
      count  <= '0;
      acc    <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          sel   <= win;
          last  <= win;
          count <= CW'(MEM_LAT - 1);
          acc   <= win ? acc_t'{we1, addr1, wdata1} : acc_t'{we0, addr0, wdata0};
        end
        ACCESS: begin
          if (!last_cyc) count <= count - CW'(1);
          else if (!acc.we) begin
            if (sel) rdata1 <= mem_rd;
            else     rdata0 <= mem_rd;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_adr = acc.adr;
  assign mem_wd  = acc.wd;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table on a MEM_LAT=2 instance,
// hand sequences for reset mid-access and a MEM_LAT=1 instance.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req0, we0, req1, we1, ack0, ack1, mem_we;
  logic [31:0] addr0, wdata0, addr1, wdata1, rdata0, rdata1, mem_adr, mem_wd, mem_rd;
  logic [1:0]  gnt;

  logic        l_req0, l_we0, l_req1, l_we1, l_ack0, l_ack1, l_mem_we;
  logic [31:0] l_addr0, l_wdata0, l_addr1, l_wdata1, l_rdata0, l_rdata1, l_mem_adr, l_mem_wd, l_mem_rd;
  logic [1:0]  l_gnt;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .gnt(gnt), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .req0(l_req0), .we0(l_we0), .addr0(l_addr0), .wdata0(l_wdata0), .ack0(l_ack0), .rdata0(l_rdata0),
    .req1(l_req1), .we1(l_we1), .addr1(l_addr1), .wdata1(l_wdata1), .ack1(l_ack1), .rdata1(l_rdata1),
    .gnt(l_gnt), .mem_adr(l_mem_adr), .mem_wd(l_mem_wd), .mem_we(l_mem_we), .mem_rd(l_mem_rd)
  );

  typedef struct {
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1, mrd;
    logic [1:0]  g;
    logic        k0, k1, mwe;
    logic [31:0] adr, wd, rd0, rd1;
  } vec_t;

  vec_t vq[$];
  int   errs = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r0, w0, input logic [31:0] a0, d0,
                     input logic r1, w1, input logic [31:0] a1, d1, mrd,
                     input logic [1:0] g, input logic k0, k1, mwe,
                     input logic [31:0] adr, wd, rd0, rd1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.mrd = mrd;
    v.g = g; v.k0 = k0; v.k1 = k1; v.mwe = mwe;
    v.adr = adr; v.wd = wd; v.rd0 = rd0; v.rd1 = rd1;
    vq.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    {req0, we0, req1, we1} = '0;
    {addr0, wdata0, addr1, wdata1, mem_rd} = '0;
    {l_req0, l_we0, l_req1, l_we1} = '0;
    {l_addr0, l_wdata0, l_addr1, l_wdata1, l_mem_rd} = '0;

    // c0-c4: port 0 read of 0x10
    add(1,0,'h10,0, 0,0,0,0, 0,           2'b00,0,0,0, 'h0,  0, 0, 0);
    add(1,0,'h10,0, 0,0,0,0, 0,           2'b01,0,0,0, 'h10, 0, 0, 0);
    add(1,0,'h10,0, 0,0,0,0, 'hDEADBEEF,  2'b01,0,0,0, 'h10, 0, 0, 0);
    add(1,0,'h10,0, 0,0,0,0, 0,           2'b01,1,0,0, 'h10, 0, 'hDEADBEEF, 0);
    add(0,0,'h10,0, 0,0,0,0, 0,           2'b00,0,0,0, 'h10, 0, 'hDEADBEEF, 0);
    // c5-c9: port 1 write of 0x12345678 to 0x40
    add(0,0,'h10,0, 1,1,'h40,'h12345678, 0,     2'b00,0,0,0, 'h10, 0,           'hDEADBEEF, 0);
    add(0,0,'h10,0, 1,1,'h40,'h12345678, 0,     2'b10,0,0,0, 'h40, 'h12345678, 'hDEADBEEF, 0);
    add(0,0,'h10,0, 1,1,'h40,'h12345678, 'hBAD, 2'b10,0,0,1, 'h40, 'h12345678, 'hDEADBEEF, 0);
    add(0,0,'h10,0, 1,1,'h40,'h12345678, 0,     2'b10,0,1,0, 'h40, 'h12345678, 'hDEADBEEF, 0);
    add(0,0,'h10,0, 0,0,'h40,0,          0,     2'b00,0,0,0, 'h40, 'h12345678, 'hDEADBEEF, 0);
    // c10-c25: both requesters held high, grants alternate 0,1,0,1
    add(1,0,'h100,0, 1,0,'h200,0, 0,          2'b00,0,0,0, 'h40,  'h12345678, 'hDEADBEEF, 0);
    add(1,0,'h100,0, 1,0,'h200,0, 0,          2'b01,0,0,0, 'h100, 0, 'hDEADBEEF, 0);
    add(1,0,'h100,0, 1,0,'h200,0, 'h11111111, 2'b01,0,0,0, 'h100, 0, 'hDEADBEEF, 0);
    add(1,0,'h100,0, 1,0,'h200,0, 0,          2'b01,1,0,0, 'h100, 0, 'h11111111, 0);
    add(1,0,'h100,0, 1,0,'h200,0, 0,          2'b00,0,0,0, 'h100, 0, 'h11111111, 0);
    add(1,0,'h100,0, 1,0,'h200,0, 0,          2'b10,0,0,0, 'h200, 0, 'h11111111, 0);
    add(1,0,'h100,0, 1,0,'h200,0, 'h22222222, 2'b10,0,0,0, 'h200, 0, 'h11111111, 0);
    add(1,0,'h100,0, 1,0,'h200,0, 0,          2'b10,0,1,0, 'h200, 0, 'h11111111, 'h22222222);
    add(1,0,'h100,0, 1,0,'h200,0, 0,          2'b00,0,0,0, 'h200, 0, 'h11111111, 'h22222222);
    add(1,0,'h100,0, 1,0,'h200,0, 0,          2'b01,0,0,0, 'h100, 0, 'h11111111, 'h22222222);
    add(1,0,'h100,0, 1,0,'h200,0, 'h33333333, 2'b01,0,0,0, 'h100, 0, 'h11111111, 'h22222222);
    add(1,0,'h100,0, 1,0,'h200,0, 0,          2'b01,1,0,0, 'h100, 0, 'h33333333, 'h22222222);
    add(1,0,'h100,0, 1,0,'h200,0, 0,          2'b00,0,0,0, 'h100, 0, 'h33333333, 'h22222222);
    add(1,0,'h100,0, 1,0,'h200,0, 0,          2'b10,0,0,0, 'h200, 0, 'h33333333, 'h22222222);
    add(1,0,'h100,0, 1,0,'h200,0, 'hAAAA5555, 2'b10,0,0,0, 'h200, 0, 'h33333333, 'h22222222);
    add(1,0,'h100,0, 1,0,'h200,0, 0,          2'b10,0,1,0, 'h200, 0, 'h33333333, 'hAAAA5555);
    // c26-c30: port 0 read must not disturb rdata1
    add(1,0,'h100,0, 0,0,'h200,0, 0,          2'b00,0,0,0, 'h200, 0, 'h33333333, 'hAAAA5555);
    add(1,0,'h100,0, 0,0,'h200,0, 0,          2'b01,0,0,0, 'h100, 0, 'h33333333, 'hAAAA5555);
    add(1,0,'h100,0, 0,0,'h200,0, 'h1,        2'b01,0,0,0, 'h100, 0, 'h33333333, 'hAAAA5555);
    add(1,0,'h100,0, 0,0,'h200,0, 0,          2'b01,1,0,0, 'h100, 0, 'h1, 'hAAAA5555);
    add(0,0,'h100,0, 0,0,'h200,0, 0,          2'b00,0,0,0, 'h100, 0, 'h1, 'hAAAA5555);
    // c31-c35: port 1 read whose req/addr/we change after the latch edge
    add(0,0,'h100,0, 1,0,'h44,0,      0,          2'b00,0,0,0, 'h100, 0, 'h1, 'hAAAA5555);
    add(0,0,'h100,0, 0,1,'h99,'hFFFF, 0,          2'b10,0,0,0, 'h44,  0, 'h1, 'hAAAA5555);
    add(0,0,'h100,0, 0,1,'h99,'hFFFF, 'h5A5A5A5A, 2'b10,0,0,0, 'h44,  0, 'h1, 'hAAAA5555);
    add(0,0,'h100,0, 0,0,'h99,0,      0,          2'b10,0,1,0, 'h44,  0, 'h1, 'h5A5A5A5A);
    add(0,0,'h100,0, 0,0,'h99,0,      0,          2'b00,0,0,0, 'h44,  0, 'h1, 'h5A5A5A5A);

    #12;
    chk("rst_gnt", gnt, 0);
    chk("rst_ack", {ack0, ack1}, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_adr", mem_adr, 0);
    chk("rst_mem_wd", mem_wd, 0);
    chk("rst_rdata", rdata0 | rdata1, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      req0 = vq[i].r0; we0 = vq[i].w0; addr0 = vq[i].a0; wdata0 = vq[i].d0;
      req1 = vq[i].r1; we1 = vq[i].w1; addr1 = vq[i].a1; wdata1 = vq[i].d1;
      mem_rd = vq[i].mrd;
      @(negedge clk);
      chk($sformatf("c%0d_gnt", i), gnt, vq[i].g);
      chk($sformatf("c%0d_ack0", i), ack0, vq[i].k0);
      chk($sformatf("c%0d_ack1", i), ack1, vq[i].k1);
      chk($sformatf("c%0d_mem_we", i), mem_we, vq[i].mwe);
      chk($sformatf("c%0d_mem_adr", i), mem_adr, vq[i].adr);
      chk($sformatf("c%0d_mem_wd", i), mem_wd, vq[i].wd);
      chk($sformatf("c%0d_rdata0", i), rdata0, vq[i].rd0);
      chk($sformatf("c%0d_rdata1", i), rdata1, vq[i].rd1);
      tick();
    end

    // Reset asserted during the strobe cycle of a port 0 write
    req0 = 1'b1; we0 = 1'b1; addr0 = 'h80; wdata0 = 'hCAFE; mem_rd = '0;
    tick();
    chk("rw_c1_gnt", gnt, 2'b01);
    chk("rw_c1_mem_we", mem_we, 0);
    tick();
    chk("rw_c2_mem_we", mem_we, 1);
    chk("rw_c2_mem_wd", mem_wd, 'hCAFE);
    #2 reset = 1'b1;
    #1;
    chk("rw_async_mem_we", mem_we, 0);
    chk("rw_async_gnt", gnt, 0);
    chk("rw_async_rdata1", rdata1, 0);
    req0 = 1'b0; we0 = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rw_idle%0d_ack0", i), ack0, 0);
      chk($sformatf("rw_idle%0d_gnt", i), gnt, 0);
      tick();
    end
    req0 = 1'b1; req1 = 1'b1; addr0 = 'h8; addr1 = 'hC; wdata0 = '0;
    tick();
    chk("post_rst_tie_gnt", gnt, 2'b01);
    chk("post_rst_tie_adr", mem_adr, 'h8);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
    chk("dropped_req_ack0", ack0, 1);
    chk("dropped_req_ack1", ack1, 0);
    tick();

    // MEM_LAT=1 instance
    l_req0 = 1'b1; l_addr0 = 'h30;
    @(negedge clk);
    chk("l1_c0_gnt", l_gnt, 0);
    tick();
    chk("l1_c1_gnt", l_gnt, 2'b01);
    chk("l1_c1_adr", l_mem_adr, 'h30);
    chk("l1_c1_we", l_mem_we, 0);
    l_mem_rd = 'h77;
    tick();
    chk("l1_c2_ack0", l_ack0, 1);
    chk("l1_c2_rdata0", l_rdata0, 'h77);
    l_req0 = 1'b0; l_mem_rd = '0;
    tick();
    chk("l1_c3_gnt", l_gnt, 0);
    chk("l1_c3_ack0", l_ack0, 0);
    l_req1 = 1'b1; l_we1 = 1'b1; l_addr1 = 'h34; l_wdata1 = 'h55;
    tick();
    chk("l1_w_c1_we", l_mem_we, 1);
    chk("l1_w_c1_gnt", l_gnt, 2'b10);
    l_req1 = 1'b0; l_we1 = 1'b0;
    tick();
    chk("l1_w_c2_ack1", l_ack1, 1);
    chk("l1_w_c2_we", l_mem_we, 0);
    chk("l1_w_c2_rdata1", l_rdata1, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
